// File: rtl/ex_mem_pkg.sv
// Shared constants and mode decode for the execute-to-memory pipeline register.
// Widths, enable levels and stall-vector bit positions live here.
package ex_mem_pkg;

  localparam int reg_w        = 32;
  localparam int reg_addr_w   = 5;
  localparam int double_reg_w = 2 * reg_w;
  localparam int stall_w      = 6;

  localparam int stall_ex  = 3;
  localparam int stall_mem = 4;

  localparam logic rst_enable    = 1'b1;
  localparam logic write_enable  = 1'b1;
  localparam logic write_disable = 1'b0;
  localparam logic stop          = 1'b1;
  localparam logic no_stop       = 1'b0;

  localparam logic [reg_w-1:0] zero_word = '0;

  typedef enum logic [1:0] {
    MODE_PASS   = 2'd0,
    MODE_BUBBLE = 2'd1,
    MODE_HOLD   = 2'd2,
    MODE_CLEAR  = 2'd3
  } mode_e;

  // Flush wins, then the ex/mem stall pair; a running ex always passes,
  // even when ctrl illegally stops mem behind it.
  function automatic mode_e decode_mode(input logic flush, input logic ex_stop,
                                        input logic mem_stop);
    if (flush)
      return MODE_CLEAR;
    else if (ex_stop == stop && mem_stop == no_stop)
      return MODE_BUBBLE;
    else if (ex_stop == no_stop)
      return MODE_PASS;
    else
      return MODE_HOLD;
  endfunction

endpackage

// File: rtl/ex_mem.sv
// EX/MEM pipeline register: latches execute results and the multiply-accumulate
// intermediate product/cycle index fed back to execute while it is stalled.
module ex_mem
  import ex_mem_pkg::*;
#(
  parameter int DATA_W  = reg_w,
  parameter int ADDR_W  = reg_addr_w,
  parameter int STALL_W = stall_w
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [STALL_W-1:0]  stall,
  input  logic                flush,
  input  logic [ADDR_W-1:0]   ex_wd,
  input  logic                ex_wreg,
  input  logic [DATA_W-1:0]   ex_wdata,
  input  logic [DATA_W-1:0]   ex_hi,
  input  logic [DATA_W-1:0]   ex_lo,
  input  logic                ex_whilo,
  input  logic [2*DATA_W-1:0] hilo_i,
  input  logic [1:0]          cnt_i,
  output logic [ADDR_W-1:0]   mem_wd,
  output logic                mem_wreg,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W-1:0]   mem_hi,
  output logic [DATA_W-1:0]   mem_lo,
  output logic                mem_whilo,
  output logic [2*DATA_W-1:0] hilo_o,
  output logic [1:0]          cnt_o
);

  mode_e mode;

  assign mode = decode_mode(flush, stall[stall_ex], stall[stall_mem]);

  always_ff @(posedge clk) begin
    if (rst == rst_enable) begin
      mem_wd    <= '0;
      mem_wreg  <= write_disable;
      mem_wdata <= '0;
      mem_hi    <= '0;
      mem_lo    <= '0;
      mem_whilo <= write_disable;
      hilo_o    <= '0;
      cnt_o     <= '0;
    end else begin
      case (mode)
        MODE_CLEAR: begin
          mem_wd    <= '0;
          mem_wreg  <= write_disable;
          mem_wdata <= '0;
          mem_hi    <= '0;
          mem_lo    <= '0;
          mem_whilo <= write_disable;
          hilo_o    <= '0;
          cnt_o     <= '0;
        end
        // Bubble into mem but keep the partial product so execute can resume.
        MODE_BUBBLE: begin
          mem_wd    <= '0;
          mem_wreg  <= write_disable;
          mem_wdata <= '0;
          mem_hi    <= '0;
          mem_lo    <= '0;
          mem_whilo <= write_disable;
          hilo_o    <= hilo_i;
          cnt_o     <= cnt_i;
        end
        MODE_PASS: begin
          mem_wd    <= ex_wd;
          mem_wreg  <= ex_wreg;
          mem_wdata <= ex_wdata;
          mem_hi    <= ex_hi;
          mem_lo    <= ex_lo;
          mem_whilo <= ex_whilo;
          hilo_o    <= '0;
          cnt_o     <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule
